// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus engine: walks an N-bit vector through all 2^N patterns,
// samples the module-under-test at the end of each dwell and scores it against EXPECTED.
module truth_table_sweeper #(
  parameter int              N        = 3,
  parameter int              DWELL    = 20,
  parameter logic [2**N-1:0] EXPECTED = 8'b1001_0110
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         loop,
  input  logic         dut_out,
  output logic [N-1:0] dut_in,
  output logic         busy,
  output logic         done,
  output logic         sweep_done,
  output logic         pass,
  output logic [N:0]   err_count,
  output logic         fail_valid,
  output logic [N-1:0] first_fail_idx
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [15:0]  DWELL_LAST = 16'(DWELL - 1);
  localparam logic [N-1:0] IDX_LAST   = '1;

  state_e         state_q, state_d;
  logic [N-1:0]   idx_q, idx_d;
  logic [15:0]    dwell_q, dwell_d;
  logic [N:0]     err_q, err_d;
  logic           fv_q, fv_d;
  logic [N-1:0]   ffi_q, ffi_d;
  logic           sd_q, sd_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      dwell_q <= '0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      ffi_q   <= '0;
      sd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dwell_q <= dwell_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      ffi_q   <= ffi_d;
      sd_q    <= sd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dwell_d = dwell_q;
    err_d   = err_q;
    fv_d    = fv_q;
    ffi_d   = ffi_q;
    sd_d    = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          idx_d   = '0;
          dwell_d = '0;
          err_d   = '0;
          fv_d    = 1'b0;
          ffi_d   = '0;
        end
      end
      RUN: begin
        if (dwell_q == DWELL_LAST) begin
          // Score the pattern that has had DWELL-1 cycles to settle.
          if (dut_out != EXPECTED[idx_q]) begin
            if (err_q != '1) err_d = err_q + (N+1)'(1);
            if (!fv_q) begin
              fv_d  = 1'b1;
              ffi_d = idx_q;
            end
          end
          dwell_d = '0;
          if (idx_q == IDX_LAST) begin
            sd_d  = 1'b1;
            idx_d = '0;
            if (!loop) state_d = DONE;
          end else begin
            idx_d = idx_q + N'(1);
          end
        end else begin
          dwell_d = dwell_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Results are frozen in DONE, so pass can be derived straight from the count.
  assign busy           = (state_q == RUN);
  assign done           = (state_q == DONE);
  assign dut_in         = busy ? idx_q : '0;
  assign pass           = done && (err_q == '0);
  assign sweep_done     = sd_q;
  assign err_count      = err_q;
  assign fail_valid     = fv_q;
  assign first_fail_idx = ffi_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench: expected sweep results are queued at start and checked on each sweep_done.
module tb_truth_table_sweeper;

  typedef struct {
    int err;
    int fv;
    int ffi;
    int cyc;
  } exp_t;

  localparam bit [7:0] EXP3 = 8'b1001_0110;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ---- N=3 instance ----
  logic       start = 1'b0, loop = 1'b0, and_m = 1'b0;
  logic       dut_out, busy, done, sweep_done, pass, fail_valid;
  logic [2:0] dut_in, first_fail_idx;
  logic [3:0] err_count;

  assign dut_out = and_m ? &dut_in : ^dut_in;

  truth_table_sweeper u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .loop(loop), .dut_out(dut_out),
    .dut_in(dut_in), .busy(busy), .done(done), .sweep_done(sweep_done), .pass(pass),
    .err_count(err_count), .fail_valid(fail_valid), .first_fail_idx(first_fail_idx)
  );

  // ---- N=2, DWELL=2 instance with an AND2 under test ----
  logic       b_start = 1'b0;
  logic       b_busy, b_done, b_sd, b_pass, b_fv;
  logic [1:0] b_dut_in, b_ffi;
  logic [2:0] b_err;

  truth_table_sweeper #(.N(2), .DWELL(2), .EXPECTED(4'b1000)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(b_start), .loop(1'b0), .dut_out(&b_dut_in),
    .dut_in(b_dut_in), .busy(b_busy), .done(b_done), .sweep_done(b_sd), .pass(b_pass),
    .err_count(b_err), .fail_valid(b_fv), .first_fail_idx(b_ffi)
  );

  exp_t sb[$];
  exp_t sb2[$];
  int   e0 = 0, e0b = 0;
  int   sd_cnt = 0, sd2_cnt = 0;
  logic sd_prev = 1'b0, sd2_prev = 1'b0;

  always @(negedge clk) begin
    if (sweep_done) begin
      exp_t e;
      sd_cnt++;
      chk("sd_pulse", 32'(sd_prev), 0);
      if (sb.size() == 0) chk("sb_empty", 1, 0);
      else begin
        e = sb.pop_front();
        chk("err_count", 32'(err_count), e.err);
        chk("fail_valid", 32'(fail_valid), e.fv);
        chk("first_fail_idx", 32'(first_fail_idx), e.ffi);
        chk("sd_time", cyc - e0, e.cyc);
      end
    end
    sd_prev = sweep_done;
  end

  always @(negedge clk) begin
    if (b_sd) begin
      exp_t e;
      sd2_cnt++;
      chk("n2_sd_pulse", 32'(sd2_prev), 0);
      if (sb2.size() == 0) chk("n2_sb_empty", 1, 0);
      else begin
        e = sb2.pop_front();
        chk("n2_err_count", 32'(b_err), e.err);
        chk("n2_fail_valid", 32'(b_fv), e.fv);
        chk("n2_sd_time", cyc - e0b, e.cyc);
      end
    end
    sd2_prev = b_sd;
  end

  // Reference scoring of one sweep of the N=3 DUT against EXP3.
  function automatic void model(input bit am, output int errs, output int first);
    errs = 0;
    first = 0;
    for (int k = 0; k < 8; k++) begin
      bit [2:0] kv = 3'(k);
      bit f = am ? (kv == 3'd7) : ^kv;
      if (f != EXP3[k]) begin
        if (errs == 0) first = k;
        errs++;
      end
    end
  endfunction

  task automatic push_sweeps(input bit am, input int nsweeps);
    int errs, first;
    exp_t e;
    model(am, errs, first);
    for (int m = 1; m <= nsweeps; m++) begin
      e.err = (errs * m > 15) ? 15 : errs * m;
      e.fv  = (errs > 0) ? 1 : 0;
      e.ffi = first;
      e.cyc = 160 * m;
      sb.push_back(e);
    end
  endtask

  task automatic kick;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 e0 = cyc;
    start = 1'b0;
  endtask

  task automatic wait_sd(input int target, input int budget);
    int i = 0;
    while (sd_cnt < target && i < budget) begin
      @(negedge clk);
      #1 i++;
    end
    chk("sd_timeout", 32'(sd_cnt >= target), 1);
  endtask

  task automatic check_done(input int exp_err, input int exp_pass);
    chk("done", 32'(done), 1);
    chk("busy_done", 32'(busy), 0);
    chk("dut_in_done", 32'(dut_in), 0);
    chk("pass", 32'(pass), exp_pass);
    chk("err_final", 32'(err_count), exp_err);
  endtask

  initial begin
    int bad;
    int base;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_outs", {dut_in, busy, done, sweep_done, pass, err_count, fail_valid, first_fail_idx}, 0);
    chk("rst_outs2", {b_dut_in, b_busy, b_done, b_sd, b_pass, b_err, b_fv, b_ffi}, 0);
    rst_n = 1'b1;

    // N=2 AND2: two back-to-back sweeps, the second started from DONE
    for (int r = 0; r < 2; r++) begin
      exp_t e;
      int i = 0;
      e.err = 0; e.fv = 0; e.ffi = 0; e.cyc = 8;
      sb2.push_back(e);
      @(negedge clk) b_start = 1'b1;
      @(posedge clk);
      #1 e0b = cyc;
      b_start = 1'b0;
      chk("n2_busy", 32'(b_busy), 1);
      while (!b_done && i < 50) begin
        @(negedge clk);
        #1 i++;
      end
      chk("n2_done_time", cyc - e0b, 8);
      chk("n2_pass", 32'(b_pass), 1);
    end

    // XOR3: clean sweep
    and_m = 1'b0;
    push_sweeps(1'b0, 1);
    base = sd_cnt;
    kick();
    chk("busy_e0", 32'(busy), 1);
    chk("dut_in_e0", 32'(dut_in), 0);
    wait_sd(base + 1, 300);
    check_done(0, 1);

    // AND3: three mismatches, dut_in hold pattern
    and_m = 1'b1;
    push_sweeps(1'b1, 1);
    base = sd_cnt;
    kick();
    bad = 0;
    for (int t = 0; t < 160; t++) begin
      if (dut_in !== 3'(t / 20)) bad++;
      @(posedge clk);
      #1;
    end
    chk("dut_in_hold", bad, 0);
    wait_sd(base + 1, 300);
    check_done(3, 0);
    chk("ffi_and", 32'(first_fail_idx), 1);

    // XOR3 started from DONE: results cleared on the start edge
    and_m = 1'b0;
    push_sweeps(1'b0, 1);
    base = sd_cnt;
    kick();
    chk("clr_err", 32'(err_count), 0);
    chk("clr_fv", 32'(fail_valid), 0);
    wait_sd(base + 1, 300);
    check_done(0, 1);

    // AND3 with a stray start pulse mid-sweep
    and_m = 1'b1;
    push_sweeps(1'b1, 1);
    base = sd_cnt;
    kick();
    repeat (49) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_sd(base + 1, 300);
    check_done(3, 0);

    // AND3 with async reset at cycle 70, then a fresh sweep
    push_sweeps(1'b1, 1);
    kick();
    repeat (69) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", {dut_in, busy, done, sweep_done, pass, err_count, fail_valid, first_fail_idx}, 0);
    sb.delete();
    @(negedge clk) rst_n = 1'b1;
    push_sweeps(1'b1, 1);
    base = sd_cnt;
    kick();
    wait_sd(base + 1, 300);
    check_done(3, 0);

    // AND3 loop mode: accumulation and saturation over six sweeps
    push_sweeps(1'b1, 6);
    base = sd_cnt;
    loop = 1'b1;
    kick();
    wait_sd(base + 5, 900);
    chk("loop_busy", 32'(busy), 1);
    loop = 1'b0;
    wait_sd(base + 6, 300);
    check_done(15, 0);
    chk("loop_ffi", 32'(first_fail_idx), 1);
    chk("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
